// File: rtl/muldiv_iter_if.sv
// Handshake bundle between the microcode sequencer and the
// iterative multiply/divide unit.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: one result bit per cycle,
// with single-cycle completion for the divide special cases.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [2:0]         r_op;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    logic               w_a_sgn;
    logic               w_b_sgn;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_dz;
    logic               w_ovf;
    logic               w_neg;
    logic [WIDTH-1:0]   w_spec;

    assign w_a_sgn = (bus.op == 3'd1) || (bus.op == 3'd2) ||
                     (bus.op == 3'd4) || (bus.op == 3'd6);
    assign w_b_sgn = (bus.op == 3'd1) || (bus.op == 3'd4) ||
                     (bus.op == 3'd6);
    assign w_sa    = w_a_sgn && bus.src_a[WIDTH-1];
    assign w_sb    = w_b_sgn && bus.src_b[WIDTH-1];
    assign w_mag_a = w_sa ? -bus.src_a : bus.src_a;
    assign w_mag_b = w_sb ? -bus.src_b : bus.src_b;
    // Remainder takes the dividend's sign; everything else XORs.
    assign w_neg   = (bus.op[2] && bus.op[1]) ? w_sa : (w_sa ^ w_sb);

    assign w_dz  = bus.op[2] && (bus.src_b == '0);
    assign w_ovf = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                   (bus.src_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (bus.src_b == '1);
    assign w_spec = w_dz ? (bus.op[1] ? bus.src_a : '1)
                         : (bus.op[1] ? '0 : bus.src_a);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_nx;

    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nx = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}.
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_nx;

    assign w_shift  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial  = w_shift - {1'b0, r_opnd};
    assign w_div_nx = w_trial[WIDTH]
        ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
        : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] w_acc_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_dsel;
    logic [WIDTH-1:0]   w_dneg;
    logic [WIDTH-1:0]   w_fix;

    assign w_acc_neg = -r_acc;
    assign w_prod    = r_neg ? w_acc_neg : r_acc;
    assign w_dsel    = r_op[1] ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
    assign w_dneg    = -w_dsel;
    assign w_fix     = r_op[2] ? (r_neg ? w_dneg : w_dsel)
                     : (r_op == 3'd0) ? w_prod[WIDTH-1:0]
                     : w_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (bus.start) begin
                        r_op  <= bus.op;
                        r_neg <= w_neg;
                        r_cnt <= '0;
                        r_acc <= {{WIDTH{1'b0}},
                                  bus.op[2] ? w_mag_a : w_mag_b};
                        r_opnd <= bus.op[2] ? w_mag_b : w_mag_a;
                        if (w_dz || w_ovf) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= w_spec;
                        end else begin
                            r_state <= CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_acc <= r_op[2] ? w_div_nx : w_mul_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1))
                        r_state <= FIXUP;
                end
                FIXUP: begin
                    r_result <= w_fix;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= DONE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: vector table plus hand-written
// sequences for busy profile, ignored start, back-to-back and reset.
module tb_muldiv_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    muldiv_iter_if #(.WIDTH(32)) bus();

    muldiv_iter #(.WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, got, exp);
    endtask

    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = 0;
        res = '0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin
                lat = c;
                res = bus.result;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    int          lat;
    int          bad;
    logic [31:0] res;
    logic        seen;

    initial begin
        vecs[0]  = '{"mul_7_m3",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{"mulh_min",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[2]  = '{"mulhu_min",   3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[3]  = '{"mulhsu_m1",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
        vecs[4]  = '{"mulhu_max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[5]  = '{"mul_max",     3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34};
        vecs[6]  = '{"div_m7_2",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[7]  = '{"rem_m7_2",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[8]  = '{"divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14,       34};
        vecs[9]  = '{"remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2,        34};
        vecs[10] = '{"div_7_m2",    3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[11] = '{"rem_7_m2",    3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
        vecs[12] = '{"divu_max_1",  3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34};
        vecs[13] = '{"divu_dz",     3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[14] = '{"rem_dz",      3'd6, 32'd5,        32'd0,        32'd5,        1};
        vecs[15] = '{"div_m5_dz",   3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1};
        vecs[16] = '{"div_ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[17] = '{"rem_ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

        bus.start = 1'b0;
        bus.op    = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, res);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
        end

        // Busy profile and done pulse width, then result hold in IDLE.
        issue(3'd0, 32'd7, 32'hFFFFFFFD);
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("busy_profile_bad", 32'(bad), 32'd0);
        check("done_c34", 32'(bus.done), 32'd1);
        check("busy_c34", 32'(bus.busy), 32'd0);
        check("res_c34", bus.result, 32'hFFFFFFEB);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("res_hold", bus.result, 32'hFFFFFFEB);

        // Start during CALC is ignored.
        issue(3'd4, 32'd100, 32'd7);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin
                bus.start = 1'b1;
                bus.op    = 3'd0;
                bus.src_a = 32'd2;
                bus.src_b = 32'd2;
            end
            if (c == 6) bus.start = 1'b0;
            if (bus.done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        check("ign_lat", 32'(lat), 32'd34);
        check("ign_res", bus.result, 32'd14);

        // Start in the done cycle is accepted immediately.
        bus.start = 1'b1;
        bus.op    = 3'd7;
        bus.src_a = 32'd13;
        bus.src_b = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(lat, res);
        check("b2b_lat", 32'(lat), 32'd34);
        check("b2b_res", res, 32'd1);

        // Reset mid-divide discards the operation.
        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.done), 32'd0);
        check("mrst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("mrst_no_done", 32'(seen), 32'd0);
        issue(3'd5, 32'd100, 32'd7);
        wait_done(lat, res);
        check("post_rst_res", res, 32'd14);
        check("post_rst_lat", 32'(lat), 32'd34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative multiply/divide unit for the RV32M ops.
- Sits beside the adder/shifter execute stage: takes the same register-read operands, and its result joins the same writeback mux.
- The microcode sequencer pulses start, stalls on busy, and samples result when done is high.
- One result bit is resolved per cycle, so the unit trades latency for area like the rest of the microcoded core.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of two, 8 or greater.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- op  in  3  0=MUL 1=MULH 2=MULHSU 3=MULHU 4=DIV 5=DIVU 6=REM 7=REMU (RISC-V funct3 encoding).
- src_a  in  WIDTH  rs1 operand; multiplicand or dividend.
- src_b  in  WIDTH  rs2 operand; multiplier or divisor.
- busy  out  1  high while an operation is in flight (states CALC and FIXUP).
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- result  out  WIDTH  final value; held from done until the next accepted start.

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, result=0; counter and internal registers cleared.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded and no done is produced.
- States and transitions:
  - IDLE → CALC on start.
  - IDLE → DONE on start when a special case applies (see below).
  - CALC → FIXUP after WIDTH iterations.
  - FIXUP → DONE.
  - DONE → IDLE, or DONE → CALC/DONE if start is present in that cycle.
- Accept: start is accepted in IDLE or DONE; there is no busy stall between back-to-back ops. In that edge, op, src_a and src_b are latched; later operand changes are ignored. start while busy=1 is ignored with no queuing.
- Sign handling:
  - Signed operands are converted to magnitudes at accept.
  - Operand signedness: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM.
  - Result negation flag = sign_a XOR sign_b for product and quotient; sign_a alone for remainder.
- CALC, multiply: shift-add over a 2*WIDTH-bit accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. Uses a WIDTH+1-bit trial subtract; the remainder is restored when the borrow is set.
- FIXUP: apply the conditional two's-complement negation, then select the output.
  - MUL → low WIDTH bits of the product.
  - MULH/MULHSU/MULHU → high WIDTH bits of the product.
  - DIV/DIVU → quotient.
  - REM/REMU → remainder.
- Special cases: go straight from accept to DONE, skipping CALC.
  - Divide by zero (src_b=0, op 4..7): quotient = all ones; remainder = src_a unmodified.
  - Signed overflow (DIV/REM with src_a = 1 followed by WIDTH-1 zeros and src_b = all ones): quotient = src_a; remainder = 0.
- Latency, with start accepted at edge k:
  - Normal: done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles.
  - Special: done is high in the cycle after edge k, i.e. 1 cycle.
- Output timing:
  - done is high only in DONE.
  - result updates on the edge entering DONE and holds through IDLE.
  - busy falls in the same cycle that done rises.
- The counter is log2(WIDTH)+1 bits wide and does not wrap within one operation.

Test Plan:
- MUL, a=7, b=-3 (0xFFFFFFFD) → result=0xFFFFFFEB. done high exactly 34 cycles after start; busy=1 for cycles 1..33.
- MULH, a=0x80000000, b=0x80000000 → 0x40000000. MULHU on the same operands → 0x40000000. MULHSU, a=-1, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV, a=-7, b=2 → -3 (0xFFFFFFFD). REM on the same operands → -1. DIVU, a=100, b=7 → 14. REMU on the same operands → 2.
- DIVU, a=5, b=0 → 0xFFFFFFFF with done 1 cycle after start. REM, a=5, b=0 → 5. DIV, a=0x80000000, b=-1 → 0x80000000 in 1 cycle. REM on the same operands → 0.
- Issue start with op=MUL during CALC → ignored, and the original result is still produced. Issue start in the done cycle → accepted, busy=1 the next cycle.
- Assert rst at cycle 10 of a DIV → busy=0, done=0, result=0 immediately; no done follows. A new start after release completes normally.
